// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, fully oversampled by clk.
// One-byte RX holding register and one-byte TX buffer with valid/ready handshakes.
module spi_slave #(
   parameter int             DW   = 8,
   parameter logic [DW-1:0]  FILL = 8'hFF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           sck,
   input  logic           mosi,
   input  logic           ss_n,
   output logic           miso,
   input  logic [DW-1:0]  tx_data,
   input  logic           tx_wr,
   output logic           tx_ready,
   output logic [DW-1:0]  rx_data,
   output logic           rx_valid,
   input  logic           rx_rd,
   output logic           ovr,
   input  logic           ovr_clr,
   output logic           busy
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

   // [0],[1] are the synchronizer stages, [2] is the delayed copy for edge detection
   logic [2:0]     sck_sync_q, sck_sync_d;
   logic [2:0]     ss_sync_q, ss_sync_d;
   logic [2:0]     mosi_sync_q, mosi_sync_d;

   logic [CW-1:0]  cnt_q, cnt_d;
   logic [DW-1:0]  rx_sh_q, rx_sh_d;
   logic [DW-1:0]  tx_sh_q, tx_sh_d;
   logic [DW-1:0]  tx_buf_q, tx_buf_d;
   logic           tx_ready_q, tx_ready_d;
   logic [DW-1:0]  rx_data_q, rx_data_d;
   logic           rx_valid_q, rx_valid_d;
   logic           ovr_q, ovr_d;

   logic           sck_rise, sck_fall;
   logic           ss_fall, ss_rise;
   logic           frame_act;
   logic           mosi_bit;
   logic [DW-1:0]  tx_next;

   assign sck_rise  =  sck_sync_q[1] & ~sck_sync_q[2];
   assign sck_fall  = ~sck_sync_q[1] &  sck_sync_q[2];
   assign ss_fall   = ~ss_sync_q[1]  &  ss_sync_q[2];
   assign ss_rise   =  ss_sync_q[1]  & ~ss_sync_q[2];
   assign frame_act = ~ss_sync_q[1];
   assign mosi_bit  =  mosi_sync_q[1];

   // byte chosen at every load point: buffered byte if one is pending, else filler
   assign tx_next = tx_ready_q ? FILL : tx_buf_q;

   always_comb begin
      sck_sync_d  = {sck_sync_q[1:0], sck};
      ss_sync_d   = {ss_sync_q[1:0], ss_n};
      mosi_sync_d = {mosi_sync_q[1:0], mosi};

      cnt_d      = cnt_q;
      rx_sh_d    = rx_sh_q;
      tx_sh_d    = tx_sh_q;
      tx_buf_d   = tx_buf_q;
      tx_ready_d = tx_ready_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      ovr_d      = ovr_q;

      if (rx_rd) begin
         rx_valid_d = 1'b0;
      end
      if (ovr_clr) begin
         ovr_d = 1'b0;
      end

      if (ss_fall) begin
         cnt_d      = '0;
         rx_sh_d    = '0;
         tx_sh_d    = tx_next;
         tx_ready_d = 1'b1;
      end else if (ss_rise) begin
         cnt_d   = '0;
         rx_sh_d = '0;
      end else if (frame_act && sck_rise) begin
         rx_sh_d = {rx_sh_q[DW-2:0], mosi_bit};
         if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            rx_data_d  = {rx_sh_q[DW-2:0], mosi_bit};
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_rd) begin
               ovr_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (frame_act && sck_fall) begin
         if (cnt_q == '0) begin
            tx_sh_d    = tx_next;
            tx_ready_d = 1'b1;
         end else begin
            tx_sh_d = {tx_sh_q[DW-2:0], 1'b0};
         end
      end

      // a write in a load cycle lands after the load has taken the old contents
      if (tx_wr) begin
         tx_buf_d   = tx_data;
         tx_ready_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_sync_q  <= 3'b000;
         ss_sync_q   <= 3'b111;
         mosi_sync_q <= 3'b111;
         cnt_q       <= '0;
         rx_sh_q     <= '0;
         tx_sh_q     <= '0;
         tx_buf_q    <= '0;
         tx_ready_q  <= 1'b1;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         sck_sync_q  <= sck_sync_d;
         ss_sync_q   <= ss_sync_d;
         mosi_sync_q <= mosi_sync_d;
         cnt_q       <= cnt_d;
         rx_sh_q     <= rx_sh_d;
         tx_sh_q     <= tx_sh_d;
         tx_buf_q    <= tx_buf_d;
         tx_ready_q  <= tx_ready_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         ovr_q       <= ovr_d;
      end
   end

   assign miso     = frame_act ? tx_sh_q[DW-1] : 1'b1;
   assign busy     = frame_act;
   assign tx_ready = tx_ready_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign ovr      = ovr_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural mode-0 master drives the pins
// and every expected value below is hand-computed.
module tb_spi_slave;

   logic        clk;
   logic        reset;
   logic        sck;
   logic        mosi;
   logic        ss_n;
   logic        miso;
   logic [7:0]  tx_data;
   logic        tx_wr;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_rd;
   logic        ovr;
   logic        ovr_clr;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mi;

   spi_slave #(.DW(8), .FILL(8'hFF)) dut (
      .clk      (clk),
      .reset    (reset),
      .sck      (sck),
      .mosi     (mosi),
      .ss_n     (ss_n),
      .miso     (miso),
      .tx_data  (tx_data),
      .tx_wr    (tx_wr),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_rd    (rx_rd),
      .ovr      (ovr),
      .ovr_clr  (ovr_clr),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // assert ss_n; optionally hit the frame-start load cycle with a tx_wr
   task automatic ss_low(input bit wr_hit, input logic [7:0] d);
      ss_n = 1'b0;
      if (wr_hit) begin
         wait_clk(2);
         tx_data = d;
         tx_wr   = 1'b1;
         wait_clk(1);
         tx_wr   = 1'b0;
         wait_clk(5);
      end else begin
         wait_clk(8);
      end
   endtask

   task automatic ss_high();
      wait_clk(8);
      ss_n = 1'b1;
      wait_clk(8);
   endtask

   // nbits mode-0 bits, 6 clk per phase; optionally pulse rx_rd in the cycle
   // the last rising edge completes the byte (3rd clk edge after sck rises)
   task automatic xfer(input logic [7:0] mo, input int nbits, input bit rd_last,
                       output logic [7:0] mi_o);
      mi_o = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = mo[7-i];
         wait_clk(6);
         mi_o = {mi_o[6:0], miso};
         sck  = 1'b1;
         if (rd_last && i == nbits - 1) begin
            wait_clk(2);
            rx_rd = 1'b1;
            wait_clk(1);
            rx_rd = 1'b0;
            wait_clk(3);
         end else begin
            wait_clk(6);
         end
         sck = 1'b0;
      end
   endtask

   task automatic pulse_rd();
      rx_rd = 1'b1;
      wait_clk(1);
      rx_rd = 1'b0;
      wait_clk(1);
   endtask

   task automatic write_tx(input logic [7:0] d);
      tx_data = d;
      tx_wr   = 1'b1;
      wait_clk(1);
      tx_wr   = 1'b0;
      wait_clk(1);
   endtask

   initial begin
      reset   = 1'b1;
      sck     = 1'b0;
      mosi    = 1'b1;
      ss_n    = 1'b1;
      tx_data = 8'h00;
      tx_wr   = 1'b0;
      rx_rd   = 1'b0;
      ovr_clr = 1'b0;
      wait_clk(4);
      reset = 1'b0;
      wait_clk(1);

      chk("rst_miso",     32'(miso),     32'h1);
      chk("rst_tx_ready", 32'(tx_ready), 32'h1);
      chk("rst_rx_data",  32'(rx_data),  32'h00);
      chk("rst_rx_valid", 32'(rx_valid), 32'h0);
      chk("rst_ovr",      32'(ovr),      32'h0);
      chk("rst_busy",     32'(busy),     32'h0);

      // single byte with preloaded buffer
      write_tx(8'hA5);
      chk("t1_tx_ready_pre", 32'(tx_ready), 32'h0);
      ss_low(1'b0, 8'h00);
      chk("t1_busy", 32'(busy), 32'h1);
      xfer(8'h37, 8, 1'b0, mi);
      ss_high();
      chk("t1_miso_byte", 32'(mi),       32'hA5);
      chk("t1_rx_data",   32'(rx_data),  32'h37);
      chk("t1_rx_valid",  32'(rx_valid), 32'h1);
      chk("t1_tx_ready",  32'(tx_ready), 32'h1);
      chk("t1_busy_end",  32'(busy),     32'h0);
      chk("t1_miso_idle", 32'(miso),     32'h1);
      pulse_rd();
      chk("t1_rd_clears", 32'(rx_valid), 32'h0);
      pulse_rd();
      chk("t1_rd_idle",   32'(rx_valid), 32'h0);

      // empty buffer sends filler
      ss_low(1'b0, 8'h00);
      xfer(8'h55, 8, 1'b0, mi);
      ss_high();
      chk("t2_miso_fill", 32'(mi),      32'hFF);
      chk("t2_rx_data",   32'(rx_data), 32'h55);
      pulse_rd();

      // two bytes in one window without reading: overrun
      ss_low(1'b0, 8'h00);
      xfer(8'h01, 8, 1'b0, mi);
      chk("t3_rx_first", 32'(rx_data), 32'h01);
      chk("t3_ovr_mid",  32'(ovr),     32'h0);
      xfer(8'h02, 8, 1'b0, mi);
      ss_high();
      chk("t3_rx_data", 32'(rx_data), 32'h02);
      chk("t3_ovr",     32'(ovr),     32'h1);
      ovr_clr = 1'b1;
      wait_clk(1);
      ovr_clr = 1'b0;
      wait_clk(1);
      chk("t3_ovr_clr", 32'(ovr), 32'h0);
      pulse_rd();

      // rx_rd in the completion cycle of the second byte
      ss_low(1'b0, 8'h00);
      xfer(8'hC3, 8, 1'b0, mi);
      xfer(8'h9A, 8, 1'b1, mi);
      ss_high();
      chk("t4_rx_data",  32'(rx_data),  32'h9A);
      chk("t4_rx_valid", 32'(rx_valid), 32'h1);
      chk("t4_ovr",      32'(ovr),      32'h0);
      pulse_rd();

      // abort after 5 bits, then a full frame
      ss_low(1'b0, 8'h00);
      xfer(8'hF0, 5, 1'b0, mi);
      ss_high();
      chk("t5_abort_valid", 32'(rx_valid), 32'h0);
      chk("t5_abort_data",  32'(rx_data),  32'h9A);
      ss_low(1'b0, 8'h00);
      xfer(8'h3C, 8, 1'b0, mi);
      ss_high();
      chk("t5_rx_data",  32'(rx_data),  32'h3C);
      chk("t5_rx_valid", 32'(rx_valid), 32'h1);
      pulse_rd();

      // tx_wr in the frame-start load cycle with empty buffer
      ss_low(1'b1, 8'h11);
      chk("t6_tx_ready_mid", 32'(tx_ready), 32'h0);
      xfer(8'h00, 8, 1'b0, mi);
      chk("t6_first_byte", 32'(mi), 32'hFF);
      xfer(8'h00, 8, 1'b0, mi);
      ss_high();
      chk("t6_second_byte", 32'(mi),       32'h11);
      chk("t6_tx_ready",    32'(tx_ready), 32'h1);
      chk("t6_rx_data",     32'(rx_data),  32'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) for the SoC bus side.
- Counterpart of the on-chip SPI master; used as a loopback target in system simulation and as an external-facing peripheral.
- Oversamples sck/mosi/ss_n with the system clock; no logic is clocked by sck.
- Presents a one-byte receive holding register and a one-byte transmit buffer with simple valid/ready handshakes.

Parameters:
- DW, 8, frame width in bits.
- FILL, 8'hFF, byte shifted out when the transmit buffer is empty at load time (DW bits wide).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sck  in  1  SPI clock from master, asynchronous to clk.
- mosi  in  1  master-out data, asynchronous.
- ss_n  in  1  slave select, active low, asynchronous.
- miso  out  1  slave-out data.
- tx_data  in  DW  byte to send next.
- tx_wr  in  1  one-cycle write strobe for tx_data.
- tx_ready  out  1  transmit buffer empty.
- rx_data  out  DW  last complete received byte.
- rx_valid  out  1  rx_data holds an unread byte.
- rx_rd  in  1  one-cycle acknowledge; clears rx_valid.
- ovr  out  1  sticky overrun flag.
- ovr_clr  in  1  clears ovr.
- busy  out  1  synchronized ss_n is low (frame active).

Behaviour:
- Reset (synchronous, active-high) values:
  - miso=1, tx_ready=1, rx_data=0, rx_valid=0, ovr=0, busy=0.
  - Bit counter = 0, shift registers = 0, sync flops = idle (sck=0, ss_n=1, mosi=1).
- Synchronization and edge detection:
  - sck, mosi and ss_n each pass through a 2-flop synchronizer, plus one delayed copy for edge detection.
  - Edge pulses are one clk wide and occur 3 clk cycles after the pin transition.
  - Requirement: sck high and low phases each ≥ 4 clk cycles.
- Frame start (ss_n falling edge):
  - Counter cleared.
  - TX shift register loaded from the buffer if tx_ready=0, else loaded with FILL.
  - On a buffer load, tx_ready goes to 1.
- sck rising edge while ss_n low:
  - rx shift <= {rx shift[DW-2:0], mosi_sync}; counter increments.
  - When the counter reaches DW: the counter wraps to 0 and rx_data <= the completed byte in the same cycle. rx_valid is 1 the following cycle.
  - If rx_valid was already 1 and rx_rd is not asserted in that cycle, ovr is set. The new byte overwrites rx_data.
- sck falling edge while ss_n low:
  - Counter == 0 (byte boundary): load the next TX byte using the same rule as frame start.
  - Otherwise: shift the TX register left by one.
- miso:
  - Equals TX shift register MSB while synchronized ss_n is low; 1 otherwise.
  - Changes 3 clk after the sck falling edge, within the master's sample window.
- ss_n rising edge (abort or end of frame):
  - Counter cleared; a partial byte is discarded; no rx_valid is generated.
  - A TX byte already loaded is lost; the buffer is untouched.
- Transmit buffer:
  - tx_wr stores tx_data and sets tx_ready=0.
  - tx_wr while tx_ready=0 overwrites the buffer; no error is flagged.
  - tx_wr in the same cycle as a load: the load uses pre-write contents (FILL if empty); the write then lands in the buffer, leaving tx_ready=0.
- Receive handshake:
  - rx_rd clears rx_valid.
  - rx_rd in the same cycle as a new byte completion: the new byte wins, rx_valid stays 1, and ovr is not set.
  - rx_rd while rx_valid=0 is ignored.
- ovr:
  - Cleared by ovr_clr or reset.
  - If set and clear occur in the same cycle, set wins.
- sck edges while ss_n is high are ignored.
- Reset mid-frame returns all state to reset values immediately. The slave then waits for a fresh ss_n falling edge; the current frame is not resumed.

Test Plan:
- Single byte: preload tx_data=8'hA5; master asserts ss_n and clocks mosi=8'h37 -> rx_data=8'h37, rx_valid=1, master reads 8'hA5, tx_ready=1.
- Empty buffer: no tx_wr; master sends 8'h55 -> master reads 8'hFF, rx_data=8'h55.
- Back-to-back frames without rx_rd: two bytes 8'h01 then 8'h02 in one ss_n window -> rx_data=8'h02, ovr=1. Then ovr_clr -> ovr=0.
- Read/complete collision: rx_rd pulsed in the exact cycle the second byte completes -> rx_valid=1, ovr=0.
- Abort: ss_n deasserted after 5 sck rising edges of 8'hF0 -> rx_valid stays 0; next full frame 8'h3C -> rx_data=8'h3C.
- tx_wr collision: tx_wr=8'h11 in the load cycle with an empty buffer -> current byte 8'hFF, next byte 8'h11.
